// File: rtl/mod_reduce_pkg.sv
// Shared types and helpers for the sequential modular-reduction stage.
// Combinational only: no latency.
// No handshake of its own.
package mod_reduce_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The bit counter must index every product bit (2*nbits of them).
  function automatic int cnt_width(input int nbits);
    return $clog2(2 * nbits);
  endfunction

endpackage

// File: rtl/mod_reduce_seq_if.sv
// Operand/result bundle between the multiplier, the reducer and its consumer.
// No logic: no latency.
// Valid/ready on both the operand side and the result side.
interface mod_reduce_seq_if #(
  parameter int NBITS = 2048
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2*NBITS-1:0]   prod;
  logic [NBITS-1:0]     m;
  logic                 out_valid;
  logic                 out_ready;
  logic [NBITS-1:0]     res;
  logic                 err;
  logic                 busy;

  modport master (
    output in_valid, prod, m, out_ready,
    input  in_ready, out_valid, res, err, busy
  );

  modport slave (
    input  in_valid, prod, m, out_ready,
    output in_ready, out_valid, res, err, busy
  );
endinterface

// File: rtl/mod_sub_step.sv
// One restoring-remainder step: shift next product bit into r, subtract M if it fits.
// Purely combinational.
// No handshake.
module mod_sub_step #(
  parameter int NBITS = 2048
) (
  input  logic [NBITS-1:0] r,
  input  logic             bit_in,
  input  logic [NBITS-1:0] mod,
  output logic [NBITS-1:0] r_next
);
  logic [NBITS:0] t;
  logic           ge;

  // r < M on entry, so t < 2M and fits NBITS+1 bits; compare at full width.
  assign t  = {r, bit_in};
  assign ge = (t >= {1'b0, mod});

  // When ge holds the true difference is below M, so the low NBITS bits of
  // the subtraction are exact and the carry-out is always zero.
  assign r_next = ge ? (t[NBITS-1:0] - mod) : t[NBITS-1:0];
endmodule

// File: rtl/mod_reduce_seq.sv
// Reduces a 2*NBITS product modulo an NBITS modulus, one product bit per cycle.
// Result 2*NBITS edges after acceptance (m==0 flags err on the acceptance edge).
// in_ready only in IDLE; result held in DONE until out_ready.
module mod_reduce_seq
  import mod_reduce_pkg::*;
#(
  parameter int NBITS = 2048
) (
  input  logic            clk,
  input  logic            rst,
  mod_reduce_seq_if.slave bus
);
  localparam int CNTW = cnt_width(NBITS);
  localparam int PW   = 2 * NBITS;

  state_t            state;
  state_t            state_nxt;
  logic [PW-1:0]     p;
  logic [NBITS-1:0]  mod_q;
  // Remainder stays below M between steps, so NBITS bits hold it.
  logic [NBITS-1:0]  r;
  logic [NBITS-1:0]  r_next;
  logic [NBITS-1:0]  res_q;
  logic              err_q;
  logic [CNTW-1:0]   cnt;
  logic              last;

  mod_sub_step #(.NBITS(NBITS)) u_step (
    .r      (r),
    .bit_in (p[PW-1]),
    .mod    (mod_q),
    .r_next (r_next)
  );

  assign last = (cnt == '0);

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: accept in IDLE, step through RUN, hand off from DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = (bus.m == '0) ? DONE : RUN;
      RUN:     if (last)         state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs depend only on state; out_ready never reaches in_ready.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.res       = res_q;
  assign bus.err       = err_q;

  // Datapath: operand capture, one reduction step per RUN cycle, result write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p     <= '0;
      mod_q <= '0;
      r     <= '0;
      cnt   <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            p     <= bus.prod;
            mod_q <= bus.m;
            r     <= '0;
            cnt   <= CNTW'(PW - 1);
            if (bus.m == '0) begin
              res_q <= '0;
              err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          r <= r_next;
          p <= {p[PW-2:0], 1'b0};
          if (last) begin
            res_q <= r_next;
            err_q <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mod_reduce_seq.sv
// Directed NBITS=8 checks plus a randomised NBITS=64 regression against prod % m.
// Expected results are queued at stimulus time and popped when out_valid appears.
module tb_mod_reduce_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mod_reduce_seq_if #(.NBITS(8))  if8();
  mod_reduce_seq_if #(.NBITS(64)) if64();

  mod_reduce_seq #(.NBITS(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
  mod_reduce_seq #(.NBITS(64)) dut64 (.clk(clk), .rst(rst), .bus(if64));

  typedef struct packed {
    logic [63:0] res;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_exp(input string tag, output exp_t e);
    check({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
  endtask

  // One NBITS=8 operation with optional result-side stall.
  task automatic op8(input string tag, input logic [15:0] pv, input logic [7:0] mv,
                     input logic [7:0] exp_res, input logic exp_err, input int stall);
    int   lat;
    exp_t e;
    check({tag, "_in_ready"}, 64'(if8.in_ready), 64'd1);
    e.res = 64'(exp_res);
    e.err = exp_err;
    sb.push_back(e);
    if8.prod      = pv;
    if8.m         = mv;
    if8.in_valid  = 1'b1;
    if8.out_ready = (stall == 0);
    step();
    // Operands are free to change once accepted.
    if8.in_valid = 1'b0;
    if8.prod     = ~pv;
    if8.m        = ~mv;
    check({tag, "_busy"}, 64'(if8.busy), 64'd1);
    lat = 0;
    while (!if8.out_valid && lat < 100) begin
      step();
      lat++;
    end
    // Edges after the acceptance edge; m==0 is already DONE at acceptance.
    check({tag, "_lat"}, 64'(lat), (mv == 8'h00) ? 64'd0 : 64'd16);
    for (int i = 0; i < stall; i++) begin
      if8.in_valid = 1'b1;
      if8.prod     = 16'h0F0F;
      if8.m        = 8'h03;
      check({tag, "_stall_vld"}, 64'(if8.out_valid), 64'd1);
      check({tag, "_stall_res"}, 64'(if8.res), 64'(exp_res));
      check({tag, "_stall_rdy"}, 64'(if8.in_ready), 64'd0);
      step();
    end
    if8.in_valid  = 1'b0;
    if8.out_ready = 1'b1;
    pop_exp(tag, e);
    check({tag, "_vld"}, 64'(if8.out_valid), 64'd1);
    check({tag, "_res"}, 64'(if8.res), e.res);
    check({tag, "_err"}, 64'(if8.err), 64'(e.err));
    step();
    check({tag, "_handoff_vld"}, 64'(if8.out_valid), 64'd0);
    check({tag, "_handoff_rdy"}, 64'(if8.in_ready), 64'd1);
  endtask

  // One NBITS=64 operation checked against the reference remainder.
  task automatic op64(input logic [127:0] pv, input logic [63:0] mv, input int stall);
    int           lat;
    exp_t         e;
    logic [127:0] q;
    q     = pv % {64'd0, mv};
    e.res = q[63:0];
    e.err = 1'b0;
    sb.push_back(e);
    check("r64_in_ready", 64'(if64.in_ready), 64'd1);
    if64.prod      = pv;
    if64.m         = mv;
    if64.in_valid  = 1'b1;
    if64.out_ready = (stall == 0);
    step();
    if64.in_valid = 1'b0;
    if64.prod     = {$urandom, $urandom, $urandom, $urandom};
    if64.m        = {$urandom, $urandom};
    lat = 0;
    while (!if64.out_valid && lat < 300) begin
      step();
      lat++;
    end
    check("r64_lat", 64'(lat), 64'd128);
    for (int i = 0; i < stall; i++) step();
    if64.out_ready = 1'b1;
    pop_exp("r64", e);
    check("r64_vld", 64'(if64.out_valid), 64'd1);
    check("r64_res", if64.res, e.res);
    check("r64_err", 64'(if64.err), 64'(e.err));
    step();
    check("r64_handoff", 64'(if64.out_valid), 64'd0);
  endtask

  initial begin
    exp_t         dropped;
    logic [127:0] pr;
    logic [63:0]  mr;

    rst = 1'b1;
    if8.in_valid   = 1'b0; if8.prod  = '0; if8.m  = '0; if8.out_ready  = 1'b1;
    if64.in_valid  = 1'b0; if64.prod = '0; if64.m = '0; if64.out_ready = 1'b1;
    #1;
    check("rst_in_ready", 64'(if8.in_ready), 64'd1);
    check("rst_out_valid", 64'(if8.out_valid), 64'd0);
    check("rst_res", 64'(if8.res), 64'd0);
    check("rst_err", 64'(if8.err), 64'd0);
    check("rst_busy", 64'(if8.busy), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    op8("basic",   16'h1234, 8'h0B, 8'h07, 1'b0, 0);
    op8("ff_mod",  16'hFFFF, 8'hFF, 8'h00, 1'b0, 0);
    op8("small_p", 16'h0005, 8'h07, 8'h05, 1'b0, 0);
    op8("m_one",   16'hFEFF, 8'h01, 8'h00, 1'b0, 0);
    op8("m_zero",  16'hABCD, 8'h00, 8'h00, 1'b1, 0);
    op8("after_z", 16'h1234, 8'h0B, 8'h07, 1'b0, 0);
    op8("stall",   16'h1234, 8'h0B, 8'h07, 1'b0, 6);

    // Abort an operation 5 cycles into RUN with an asynchronous reset.
    dropped.res = 64'h07;
    dropped.err = 1'b0;
    sb.push_back(dropped);
    if8.prod     = 16'h1234;
    if8.m        = 8'h0B;
    if8.in_valid = 1'b1;
    step();
    if8.in_valid = 1'b0;
    repeat (5) step();
    check("abort_busy_before", 64'(if8.busy), 64'd1);
    check("abort_res_before", 64'(if8.res), 64'h07);
    rst = 1'b1;
    #1;
    check("abort_out_valid", 64'(if8.out_valid), 64'd0);
    check("abort_in_ready", 64'(if8.in_ready), 64'd1);
    check("abort_busy", 64'(if8.busy), 64'd0);
    check("abort_res", 64'(if8.res), 64'd0);
    check("abort_err", 64'(if8.err), 64'd0);
    dropped = sb.pop_back();
    @(negedge clk);
    rst = 1'b0;
    op8("post_rst", 16'h0100, 8'h0D, 8'h09, 1'b0, 0);

    for (int n = 0; n < 400; n++) begin
      pr = {$urandom, $urandom, $urandom, $urandom};
      mr = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) mr = 64'($urandom_range(1, 1000));
      if (mr == 64'd0) mr = 64'd1;
      op64(pr, mr, int'($urandom_range(0, 3)));
    end

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
